vscale_rr_arbiter: RTL and testbench
====================================

# vscale_rr_arbiter

Parametrised round-robin arbiter that multiplexes the HASTI data-memory ports of `NUM_CORES` vscale cores onto one shared dmem slave. It sits between the cores' dmem bridges and the shared data memory. It replaces externally scheduled core selection with request-driven, fair, pipelined arbitration. Address phase and data phase are tracked separately so that back-to-back transfers from different cores overlap.

## Interface
- `NUM_CORES`, 4: number of core ports, 1 to 16.
- `CORE_IDX_WIDTH`, `max(1,$clog2(NUM_CORES))`: width of the core index.
- `ADDR_WIDTH`, 32: per-core HASTI address width.
- `BUS_WIDTH`, 32: HASTI data width.
- Core port vectors are flattened; core i occupies slice `[i*W +: W]`.
- `clk` in 1: the only clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (low = in reset).
- `core_haddr` in NUM_CORES*ADDR_WIDTH: per-core address.
- `core_hwrite`, `core_hmastlock` in NUM_CORES: per-core write and lock.
- `core_hsize`, `core_hburst`, `core_hprot`, `core_htrans` in NUM_CORES*`HASTI_*_WIDTH`: per-core control.
- `core_hwdata` in NUM_CORES*BUS_WIDTH: per-core write data, data phase.
- `core_hrdata` out NUM_CORES*BUS_WIDTH: read data to each core.
- `core_hready` out NUM_CORES: address-accept strobe per core.
- `core_hresp` out NUM_CORES*`HASTI_RESP_WIDTH`: per-core response.
- `dmem_haddr` out CORE_IDX_WIDTH+ADDR_WIDTH: `{a_core, core_haddr[a_core]}`.
- `dmem_hwrite`, `dmem_hsize`, `dmem_hburst`, `dmem_hmastlock`, `dmem_hprot`, `dmem_htrans` out: muxed controls.
- `dmem_hwdata` out BUS_WIDTH: muxed write data.
- `dmem_hrdata` in BUS_WIDTH, `dmem_hready` in 1, `dmem_hresp` in `HASTI_RESP_WIDTH`: slave response.

## Operation
- A core requests when `req[i] = core_htrans[i][1]` (NONSEQ or SEQ).
- Address-phase state:
  - `a_core` is the granted core.
  - `a_valid` means a grant is held.
- Data-phase state:
  - `d_core` is the core owning the data phase.
  - `d_valid` means a data phase is active.
- Address mux:
  - When `a_valid`, all dmem address-phase outputs come from `a_core`.
  - When `!a_valid`, they are zero and `dmem_htrans` = IDLE.
- `dmem_hwdata = core_hwdata[d_core]`.
- `core_hrdata[i] = dmem_hrdata` for every i.
- `core_hresp[d_core] = dmem_hresp` when `d_valid`; all other cores get OKAY.
- `core_hready[i]`:
  - If `req[i]`: `dmem_hready & a_valid & (a_core==i)`.
  - Otherwise: `dmem_hready`, so idle cores are not stalled.
- Re-arbitration happens only on cycles with `dmem_hready=1`:
  - With any `req`: `a_core` <= the first requester scanning `a_core+1, a_core+2, …` wrapping around, with `a_core` itself last. `a_valid` <= 1.
  - With no `req`: `a_valid` <= 0; `a_core` holds.
- Data-phase update on cycles with `dmem_hready=1`: `d_core <= a_core`, `d_valid <= a_valid & req[a_core]`.
- When `dmem_hready=0`, all state holds. Ungranted cores see `hready=0` and hold their request.
- Wrap-around: index `NUM_CORES-1` is followed by 0.
- With `NUM_CORES=1`: the grant is always core 0 and the index is 1 bit, held at 0.

## Timing
- All of these reset to 0 asynchronously: `a_core`, `a_valid`, `d_core`, `d_valid`.
- Outputs in reset:
  - `dmem_htrans` = IDLE and `dmem_haddr` = 0.
  - `core_hready[i]` = `dmem_hready & !req[i]`.
  - `core_hresp` = OKAY.
- Latency from idle:
  - A request arriving while `!a_valid` is stalled one cycle.
  - It is granted the next cycle and accepted when `dmem_hready=1`.
- Sustained throughput: one accepted transfer per cycle. Grant rotates after every accepted transfer whenever another core is requesting.
- A data phase follows its address phase by exactly one cycle, stretched by `dmem_hready=0` cycles.
- Reset asserted mid-transfer: pending grant and data phase are dropped. The slave sees IDLE from the reset cycle on.

## Configuration
- Macro: `VSCALE_ARB_LOCK_EN`.
- Defined:
  - On a `dmem_hready=1` cycle with `a_valid & core_hmastlock[a_core]`, the grant stays on `a_core` and `a_valid` stays 1, even if that core drops its request.
  - Release happens on the first `dmem_hready=1` cycle with `hmastlock` low.
- Undefined: `hmastlock` is forwarded to `dmem_hmastlock` but never affects arbitration.

## Test plan
- Reset low with cores 0–3 all requesting -> `dmem_htrans`=IDLE, all `core_hready`=0. After release: cycle 1 all stalled; cycle 2 grant core 1 (scan starts after `a_core`=0); then 2, 3, 0 on consecutive cycles.
- Single core 2 reads 0x100, memory returns 0xDEADBEEF -> `dmem_haddr`=`{2'd2,32'h100}`. The next cycle `core_hrdata[2]`=0xDEADBEEF and `core_hresp[2]`=OKAY.
- Core 1 writes 0x55 then core 3 writes 0xAA back-to-back -> `dmem_hwdata`=0x55 in the cycle core 3's address is presented, then 0xAA.
- `dmem_hready` low for 3 cycles during core 0's address phase -> `dmem_haddr` stable, `d_core` and `d_valid` frozen, every `core_hready`=0.
- With `VSCALE_ARB_LOCK_EN`, core 0 issues 3 locked transfers while core 1 requests -> core 1 is granted only after core 0 drops `hmastlock`. Without the macro, grants alternate 0, 1, 0.
- Reset pulled low while core 2's data phase is active -> `d_valid`=0 immediately and `core_hresp[2]`=OKAY.

Source files
------------

// File: rtl/vscale_rr_arbiter.sv
// Round-robin arbiter for NUM_CORES HASTI dmem ports onto one slave. Define VSCALE_ARB_LOCK_EN so that hmastlock pins the grant.
// The grant registers one cycle after a request is seen. A data phase follows its address phase, and dmem_hready=0 freezes all state.
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module vscale_rr_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int CORE_IDX_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_WIDTH      = 32
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]             core_haddr,
    input  logic [NUM_CORES-1:0]                        core_hwrite,
    input  logic [NUM_CORES-1:0]                        core_hmastlock,
    input  logic [NUM_CORES*`HASTI_SIZE_WIDTH-1:0]      core_hsize,
    input  logic [NUM_CORES*`HASTI_BURST_WIDTH-1:0]     core_hburst,
    input  logic [NUM_CORES*`HASTI_PROT_WIDTH-1:0]      core_hprot,
    input  logic [NUM_CORES*`HASTI_TRANS_WIDTH-1:0]     core_htrans,
    input  logic [NUM_CORES*BUS_WIDTH-1:0]              core_hwdata,
    output logic [NUM_CORES*BUS_WIDTH-1:0]              core_hrdata,
    output logic [NUM_CORES-1:0]                        core_hready,
    output logic [NUM_CORES*`HASTI_RESP_WIDTH-1:0]      core_hresp,
    output logic [CORE_IDX_WIDTH+ADDR_WIDTH-1:0]        dmem_haddr,
    output logic                                        dmem_hwrite,
    output logic [`HASTI_SIZE_WIDTH-1:0]                dmem_hsize,
    output logic [`HASTI_BURST_WIDTH-1:0]               dmem_hburst,
    output logic                                        dmem_hmastlock,
    output logic [`HASTI_PROT_WIDTH-1:0]                dmem_hprot,
    output logic [`HASTI_TRANS_WIDTH-1:0]               dmem_htrans,
    output logic [BUS_WIDTH-1:0]                        dmem_hwdata,
    input  logic [BUS_WIDTH-1:0]                        dmem_hrdata,
    input  logic                                        dmem_hready,
    input  logic [`HASTI_RESP_WIDTH-1:0]                dmem_hresp
);

    localparam int SW = `HASTI_SIZE_WIDTH;
    localparam int BRW = `HASTI_BURST_WIDTH;
    localparam int PW = `HASTI_PROT_WIDTH;
    localparam int TW = `HASTI_TRANS_WIDTH;
    localparam int RW = `HASTI_RESP_WIDTH;

    logic [CORE_IDX_WIDTH-1:0] a_core;
    logic [CORE_IDX_WIDTH-1:0] d_core;
    logic [CORE_IDX_WIDTH-1:0] nxt_core;
    logic                      a_valid;
    logic                      d_valid;
    logic [NUM_CORES-1:0]      req;
    logic                      a_req;
    logic                      lock_hold;
    int                        rank;
    int                        best_rank;

    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic                      sel_write;
    logic                      sel_lock;
    logic [SW-1:0]             sel_size;
    logic [BRW-1:0]            sel_burst;
    logic [PW-1:0]             sel_prot;
    logic [TW-1:0]             sel_trans;
    logic [BUS_WIDTH-1:0]      sel_wdata;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            req[i] = core_htrans[i*TW + 1];
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_lock  = 1'b0;
        sel_size  = '0;
        sel_burst = '0;
        sel_prot  = '0;
        sel_trans = '0;
        sel_wdata = '0;
        a_req     = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (a_core == CORE_IDX_WIDTH'(i)) begin
                sel_addr  = core_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_write = core_hwrite[i];
                sel_lock  = core_hmastlock[i];
                sel_size  = core_hsize[i*SW +: SW];
                sel_burst = core_hburst[i*BRW +: BRW];
                sel_prot  = core_hprot[i*PW +: PW];
                sel_trans = core_htrans[i*TW +: TW];
                a_req     = req[i];
            end
            if (d_core == CORE_IDX_WIDTH'(i)) begin
                sel_wdata = core_hwdata[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Rank 0 is the core just after a_core; a_core itself ranks last.
    always_comb begin
        nxt_core  = a_core;
        best_rank = NUM_CORES;
        rank      = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            rank = (i - int'(a_core) - 1 + 2 * NUM_CORES) % NUM_CORES;
            if (req[i] && (rank < best_rank)) begin
                best_rank = rank;
                nxt_core  = CORE_IDX_WIDTH'(i);
            end
        end
    end

`ifdef VSCALE_ARB_LOCK_EN
    assign lock_hold = a_valid & sel_lock;
`else
    assign lock_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_core  <= '0;
            a_valid <= 1'b0;
            d_core  <= '0;
            d_valid <= 1'b0;
        end else if (dmem_hready) begin
            d_core  <= a_core;
            d_valid <= a_valid & a_req;
            if (lock_hold) begin
                a_valid <= 1'b1;
            end else if (|req) begin
                a_core  <= nxt_core;
                a_valid <= 1'b1;
            end else begin
                a_valid <= 1'b0;
            end
        end
    end

    assign dmem_haddr     = a_valid ? {a_core, sel_addr} : '0;
    assign dmem_hwrite    = a_valid & sel_write;
    assign dmem_hmastlock = a_valid & sel_lock;
    assign dmem_hsize     = a_valid ? sel_size  : '0;
    assign dmem_hburst    = a_valid ? sel_burst : '0;
    assign dmem_hprot     = a_valid ? sel_prot  : '0;
    assign dmem_htrans    = a_valid ? sel_trans : '0;
    assign dmem_hwdata    = sel_wdata;
    assign core_hrdata    = {NUM_CORES{dmem_hrdata}};

    // Cores that are not requesting see the raw slave ready so they are never stalled.
    always_comb begin
        core_hready = '0;
        core_hresp  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_hready[i] = req[i] ? (dmem_hready & a_valid & (a_core == CORE_IDX_WIDTH'(i)))
                                    : dmem_hready;
            if (d_valid && (d_core == CORE_IDX_WIDTH'(i))) begin
                core_hresp[i*RW +: RW] = dmem_hresp;
            end
        end
    end

endmodule

// File: tb/tb_vscale_rr_arbiter.sv
// Randomized scoreboard bench for vscale_rr_arbiter with four cores.
// A transaction-level model predicts each cycle's outputs, and a monitor compares them at the falling edge.
module tb_vscale_rr_arbiter;

    localparam int NC = 4;
    localparam int IW = 2;
    localparam int AW = 32;
    localparam int BW = 32;
    localparam int NCYC = 2100;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [NC*AW-1:0] core_haddr = '0;
    logic [NC-1:0]    core_hwrite = '0;
    logic [NC-1:0]    core_hmastlock = '0;
    logic [NC*3-1:0]  core_hsize = '0;
    logic [NC*3-1:0]  core_hburst = '0;
    logic [NC*4-1:0]  core_hprot = '0;
    logic [NC*2-1:0]  core_htrans = '0;
    logic [NC*BW-1:0] core_hwdata = '0;
    logic [NC*BW-1:0] core_hrdata;
    logic [NC-1:0]    core_hready;
    logic [NC-1:0]    core_hresp;
    logic [IW+AW-1:0] dmem_haddr;
    logic             dmem_hwrite;
    logic [2:0]       dmem_hsize;
    logic [2:0]       dmem_hburst;
    logic             dmem_hmastlock;
    logic [3:0]       dmem_hprot;
    logic [1:0]       dmem_htrans;
    logic [BW-1:0]    dmem_hwdata;
    logic [BW-1:0]    dmem_hrdata = '0;
    logic             dmem_hready = 1'b0;
    logic             dmem_hresp = 1'b0;

    vscale_rr_arbiter #(.NUM_CORES(NC), .CORE_IDX_WIDTH(IW), .ADDR_WIDTH(AW), .BUS_WIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .core_haddr(core_haddr), .core_hwrite(core_hwrite), .core_hmastlock(core_hmastlock),
        .core_hsize(core_hsize), .core_hburst(core_hburst), .core_hprot(core_hprot),
        .core_htrans(core_htrans), .core_hwdata(core_hwdata), .core_hrdata(core_hrdata),
        .core_hready(core_hready), .core_hresp(core_hresp),
        .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hsize(dmem_hsize),
        .dmem_hburst(dmem_hburst), .dmem_hmastlock(dmem_hmastlock), .dmem_hprot(dmem_hprot),
        .dmem_htrans(dmem_htrans), .dmem_hwdata(dmem_hwdata), .dmem_hrdata(dmem_hrdata),
        .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0]    hready;
        logic [IW+AW-1:0] haddr;
        logic [1:0]       htrans;
        logic             hwrite;
        logic             hlock;
        logic [2:0]       hsize;
        logic [2:0]       hburst;
        logic [3:0]       hprot;
        logic [BW-1:0]    hwdata;
        logic [BW-1:0]    hrdata;
        logic [NC-1:0]    hresp;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   stim_done = 1'b0;

    // Per-core bus master state held by the bench.
    logic [AW-1:0] c_addr[NC];
    logic          c_write[NC];
    logic          c_lock[NC];
    logic [2:0]    c_size[NC];
    logic [2:0]    c_burst[NC];
    logic [3:0]    c_prot[NC];
    logic [1:0]    c_trans[NC];
    logic [BW-1:0] c_wdata[NC];
    bit            pend[NC];

    // Reference model state: address-phase owner, data-phase owner.
    int m_a = 0;
    bit m_av = 1'b0;
    int m_d = 0;
    bit m_dv = 1'b0;

    function automatic int rr_pick(int last, logic [NC-1:0] r);
        int order[$];
        int pick;
        bit found;
        pick = last;
        found = 1'b0;
        for (int k = 1; k <= NC; k++) order.push_back((last + k) % NC);
        for (int j = 0; j < NC; j++) begin
            if (!found && r[order[j]]) begin
                found = 1'b1;
                pick = order[j];
            end
        end
        return pick;
    endfunction

    function automatic logic [NC-1:0] cur_req();
        logic [NC-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = c_trans[i][1];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NC; i++) begin
            core_haddr[i*AW +: AW]  = c_addr[i];
            core_hwrite[i]          = c_write[i];
            core_hmastlock[i]       = c_lock[i];
            core_hsize[i*3 +: 3]    = c_size[i];
            core_hburst[i*3 +: 3]   = c_burst[i];
            core_hprot[i*4 +: 4]    = c_prot[i];
            core_htrans[i*2 +: 2]   = c_trans[i];
            core_hwdata[i*BW +: BW] = c_wdata[i];
        end
    endtask

    initial begin : stimulus
        logic [NC-1:0] req_now;
        logic [NC-1:0] prev_hready;
        exp_t e;
        prev_hready = '0;
        for (int i = 0; i < NC; i++) begin
            c_addr[i] = '0; c_write[i] = 1'b0; c_lock[i] = 1'b0; c_size[i] = '0;
            c_burst[i] = '0; c_prot[i] = '0; c_trans[i] = '0; c_wdata[i] = '0; pend[i] = 1'b0;
        end
        drive_bus();
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            // Clock edge just taken, using the inputs that were applied during the last cycle.
            req_now = cur_req();
            if (reset && dmem_hready) begin
                m_d  = m_a;
                m_dv = m_av && req_now[m_a];
`ifdef VSCALE_ARB_LOCK_EN
                if (m_av && c_lock[m_a]) m_av = 1'b1;
                else
`endif
                if (|req_now) begin
                    m_a  = rr_pick(m_a, req_now);
                    m_av = 1'b1;
                end else begin
                    m_av = 1'b0;
                end
            end
            for (int i = 0; i < NC; i++)
                if (pend[i] && req_now[i] && prev_hready[i]) pend[i] = 1'b0;

            // New inputs for this cycle.
            reset = !((c < 3) || (c >= 700 && c < 702) || (c == 1400));
            dmem_hready = (c < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            dmem_hrdata = $urandom;
            dmem_hresp  = 1'($urandom_range(0, 1));
            for (int i = 0; i < NC; i++) begin
                if (!pend[i] && ((c < 20) || ($urandom_range(0, 2) == 0))) begin
                    pend[i]    = 1'b1;
                    c_addr[i]  = $urandom;
                    c_write[i] = 1'($urandom_range(0, 1));
                    c_lock[i]  = 1'($urandom_range(0, 1));
                    c_size[i]  = 3'($urandom_range(0, 2));
                    c_burst[i] = 3'($urandom_range(0, 7));
                    c_prot[i]  = 4'($urandom_range(0, 15));
                    c_trans[i] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
                end else if (!pend[i]) begin
                    c_trans[i] = 2'($urandom_range(0, 1));
                    c_lock[i]  = 1'($urandom_range(0, 1));
                end
                c_wdata[i] = $urandom;
            end
            drive_bus();
            if (!reset) begin
                m_a = 0; m_av = 1'b0; m_d = 0; m_dv = 1'b0;
            end

            // Expected outputs for this cycle.
            req_now = cur_req();
            for (int i = 0; i < NC; i++) begin
                e.hready[i] = req_now[i] ? (dmem_hready && m_av && (m_a == i)) : dmem_hready;
                e.hresp[i]  = (m_dv && (m_d == i)) ? dmem_hresp : 1'b0;
            end
            if (m_av) begin
                e.haddr  = {IW'(m_a), c_addr[m_a]};
                e.htrans = c_trans[m_a];
                e.hwrite = c_write[m_a];
                e.hlock  = c_lock[m_a];
                e.hsize  = c_size[m_a];
                e.hburst = c_burst[m_a];
                e.hprot  = c_prot[m_a];
            end else begin
                e.haddr = '0; e.htrans = 2'b00; e.hwrite = 1'b0; e.hlock = 1'b0;
                e.hsize = '0; e.hburst = '0; e.hprot = '0;
            end
            e.hwdata = c_wdata[m_d];
            e.hrdata = dmem_hrdata;
            sbq.push_back(e);
            prev_hready = e.hready;
        end
        @(posedge clk);
        #2;
        stim_done = 1'b1;
        repeat (2) @(posedge clk);
        chk("sb_drain", 128'(sbq.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                if (!stim_done && cyc > 0) chk("sb_underflow", 128'd0, 128'd1);
            end else begin
                e = sbq.pop_front();
                chk("core_hready", 128'(core_hready), 128'(e.hready));
                chk("dmem_haddr", 128'(dmem_haddr), 128'(e.haddr));
                chk("dmem_htrans", 128'(dmem_htrans), 128'(e.htrans));
                chk("dmem_ctrl", 128'({dmem_hwrite, dmem_hmastlock, dmem_hsize, dmem_hburst, dmem_hprot}),
                    128'({e.hwrite, e.hlock, e.hsize, e.hburst, e.hprot}));
                chk("dmem_hwdata", 128'(dmem_hwdata), 128'(e.hwdata));
                chk("core_hrdata", 128'(core_hrdata), 128'({NC{e.hrdata}}));
                chk("core_hresp", 128'(core_hresp), 128'(e.hresp));
            end
        end
    end

endmodule
